sccb_write_master: RTL and testbench
====================================

# sccb_write_master

Serial camera-control bus (SCCB/I2C-compatible) write engine for the OV5640 init path. It sits directly downstream of the OV5640 register-configuration sequencer. Each `cfg_start` pulse accepts one 24-bit `{reg_addr[15:0], reg_val[7:0]}` word and issues a 3-phase SCCB write: device ID, address high, address low, then data. It returns a one-cycle `cfg_end` pulse when the STOP condition completes, so the sequencer can advance.

## Interface
- `DEVICE_ID`, 7'h3C: 7-bit slave address; the transmitted first byte is `{DEVICE_ID,1'b0}` = 8'h78.
- `SYS_CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz.
- `SCL_FREQ`, 250_000: target SCL frequency in Hz.
- Derived `QTR = SYS_CLK_FREQ/(4*SCL_FREQ)`: sys_clk cycles per quarter SCL period. `QTR >= 2` is required; the default gives 50.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: asynchronous reset, active-high.
- `cfg_start` in 1: one-cycle request; sampled only in IDLE.
- `cfg_data` in 24: `{reg_addr[15:0], reg_val[7:0]}`; captured on the accepted `cfg_start`.
- `cfg_end` out 1: one-cycle pulse when a transaction finishes.
- `busy` out 1: high from the cycle after acceptance until the `cfg_end` cycle inclusive.
- `ack_err` out 1: sticky NACK flag; cleared on accept or on reset.
- `scl` out 1: SCCB clock, push-pull.
- `sda_oe` out 1: 1 = drive SDA low; 0 = release (pull-up high).
- `sda_i` in 1: SDA pad input, already synchronised externally.

## Operation
- States: IDLE → START → BIT → STOP → DONE → IDLE.
- **IDLE:** `scl`=1, `sda_oe`=0.
  - `cfg_start`=1 latches `cfg_data` into a 32-bit shift register `{8'h78, cfg_data}` and clears the bit counter (0..35) and the quarter counter.
  - `cfg_start` outside IDLE is ignored. It is not queued.
- **Quarter counter:** counts 0..QTR-1 and emits a tick on wrap. Each state step is one quarter index q0..q3.
- **START** (4 quarters):
  - q0: SDA released, SCL high.
  - q1: SDA driven low, SCL high.
  - q2, q3: SCL low.
- **BIT**: 36 bits, i.e. 4 bytes of 8 data bits plus 1 ACK bit each, MSB first.
  - q0: SCL low; update SDA. For a data bit, `sda_oe = ~bit`. For an ACK slot, `sda_oe`=0.
  - q1: SCL rises.
  - q2: SCL high; ACK slots sample `sda_i` at the last cycle of q2.
  - q3: SCL falls.
- SDA changes only while SCL is low, except in START and STOP.
- **STOP** (4 quarters):
  - q0: SCL low, SDA low.
  - q1: SCL high, SDA low.
  - q2: SCL high, SDA released.
  - q3: hold (bus-free time).
- **DONE:** one sys_clk cycle; `cfg_end`=1; the next cycle returns to IDLE.
- **Reset** (any time, including mid-transfer):
  - Immediately: `scl`=1, `sda_oe`=0, `cfg_end`=0, `busy`=0, `ack_err`=0.
  - State returns to IDLE and counters clear.
  - No `cfg_end` is produced for the aborted word.

## Timing
- Latency: `cfg_start` sampled at edge k → `cfg_end` high during cycle k+1+152·QTR, which is the only `cfg_end` cycle. 152 = 4 (START) + 144 (BIT) + 4 (STOP).
- Earliest next accept is the cycle after `cfg_end`. A `cfg_start` coincident with `cfg_end` is ignored.
  - The upstream sequencer pulses `cfg_start` the cycle after `cfg_end`, which is legal.
- SCL period is 4·QTR sys_clk cycles, with a 50 % duty cycle during BIT.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - A high `sda_i` sampled in any ACK slot sets `ack_err` and jumps to STOP at the next q0.
  - The remaining bits are skipped. STOP and DONE still run, so `cfg_end` still pulses.
  - Latency for an abort at byte n (0..3): k+1+(4+36·(n+1)+4)·QTR.
- `SCCB_ACK_CHECK_EN` undefined:
  - The ACK slot is a don't-care bit per SCCB. `sda_i` is unused.
  - `ack_err` is tied to 0, and latency is always 152·QTR+1.

## Test plan
- **Basic write:** SYS_CLK_FREQ=1600, SCL_FREQ=100 (QTR=4). Pulse `cfg_start` with `cfg_data`=24'h300882; slave model ACKs.
  - Required: bytes 78, 30, 08, 82 are decoded on SCL rising edges.
  - Required: `cfg_end` is high exactly 609 cycles after the `cfg_start` edge, for 1 cycle.
  - Required: `busy` spans that window and `ack_err`=0.
- **Back-to-back:** after `cfg_end`, pulse `cfg_start`=24'h3017ff on the next cycle.
  - Required: accepted; bytes 78, 30, 17, FF; no SCL glitch between the transactions.
- **Ignored request:** pulse `cfg_start` with 24'h123456 mid-transfer.
  - Required: the current bytes are unchanged and no extra transaction follows.
- **NACK (macro defined):** slave NACKs the address-high byte.
  - Required: `ack_err`=1, STOP issued, `cfg_end` at 4+72+4=80 quarters → cycle 321.
- **NACK (macro undefined):** same stimulus.
  - Required: full 36 bits sent, `ack_err`=0, `cfg_end` at cycle 609.
- **Reset mid-transfer:** assert `sys_rst` during bit 20.
  - Required: within the same cycle `scl`=1 and `sda_oe`=0.
  - Required: no `cfg_end`; a new `cfg_start` after release produces a full transaction.

Source files
------------

// File: rtl/sccb_write_master.sv
// sccb_write_master
//
// SCCB (I2C-compatible) write engine for the OV5640 init path. Each accepted
// cfg_start sends one 3-phase write: {DEVICE_ID,0}, reg_addr[15:8],
// reg_addr[7:0], reg_val. cfg_end pulses for one cycle when the transfer,
// including its STOP condition, is complete.
//
// Build option: SCCB_ACK_CHECK_EN
//   defined   - a NACK in any ACK slot sets ack_err and cuts the transfer
//               short to STOP; cfg_end still pulses.
//   undefined - ACK slots are don't-care, ack_err stays 0.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous reset, active high
//   cfg_start  in   one-cycle request, honoured only when idle
//   cfg_data   in   {reg_addr[15:0], reg_val[7:0]}, captured on accept
//   cfg_end    out  one-cycle completion pulse
//   busy       out  high from accept through the cfg_end cycle
//   ack_err    out  sticky NACK flag, cleared on accept
//   scl        out  SCCB clock, push-pull
//   sda_oe     out  1 = pull SDA low, 0 = release
//   sda_i      in   SDA pad input, already synchronised
//
// State      | meaning
// S_IDLE     | bus free, waiting for cfg_start
// S_START    | START condition, quarters q0..q3
// S_BIT      | 36 bit slots (4 x (8 data + 1 ACK)), MSB first
// S_STOP     | STOP condition plus bus-free hold
// S_DONE     | single cycle, raises cfg_end on the following cycle
module sccb_write_master #(
    parameter logic [6:0] DEVICE_ID    = 7'h3C,
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int QTR = SYS_CLK_FREQ / (4 * SCL_FREQ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

`ifdef SCCB_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_qidx;
    logic [5:0]    r_bit;
    logic [31:0]   r_shift;
    logic          r_scl;
    logic          r_sda_oe;
    logic          r_cfg_end;
    logic          r_busy;
    logic          r_ack_err;

    logic w_scl_nxt;
    logic w_sda_oe_nxt;
    logic w_accept;
    logic w_active;
    logic w_tick;
    logic w_qend;
    logic w_ack_slot;
    logic w_nack_sample;

    // r_cfg_end marks the cycle after DONE; blocking accept there keeps a
    // request coincident with cfg_end from starting a new transfer.
    assign w_accept   = (r_state == S_IDLE) && cfg_start && !r_cfg_end;
    assign w_active   = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
    assign w_tick     = (r_qcnt == QTR_LAST);
    assign w_qend     = w_tick && (r_qidx == 2'd3);
    assign w_ack_slot = (r_bit == 6'd8) || (r_bit == 6'd17) || (r_bit == 6'd26) || (r_bit == 6'd35);

    // Pins lag the state by one registered cycle, so the first cycle of
    // internal q3 is the last cycle SCL is actually high in q2.
    assign w_nack_sample = ACK_CHECK && (r_state == S_BIT) && w_ack_slot &&
                           (r_qidx == 2'd3) && (r_qcnt == '0) && sda_i;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_scl_nxt    = 1'b1;
        w_sda_oe_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                w_scl_nxt    = (r_qidx == 2'd0) || (r_qidx == 2'd1);
                w_sda_oe_nxt = (r_qidx != 2'd0);
                if (w_qend) w_state_nxt = S_BIT;
            end
            S_BIT: begin
                w_scl_nxt    = (r_qidx == 2'd1) || (r_qidx == 2'd2);
                w_sda_oe_nxt = !w_ack_slot && !r_shift[31];
                if (w_qend && ((r_bit == 6'd35) || r_ack_err)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_scl_nxt    = (r_qidx != 2'd0);
                w_sda_oe_nxt = (r_qidx == 2'd0) || (r_qidx == 2'd1);
                if (w_qend) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_qcnt    <= '0;
            r_qidx    <= 2'd0;
            r_bit     <= 6'd0;
            r_shift   <= 32'd0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_cfg_end <= 1'b0;
            r_busy    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_scl     <= w_scl_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_cfg_end <= (r_state == S_DONE);

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_cfg_end) begin
                r_busy <= 1'b0;
            end

            if (w_accept) begin
                r_shift   <= {DEVICE_ID, 1'b0, cfg_data};
                r_qcnt    <= '0;
                r_qidx    <= 2'd0;
                r_bit     <= 6'd0;
                r_ack_err <= 1'b0;
            end else if (w_active) begin
                r_qcnt <= w_tick ? '0 : r_qcnt + QW'(1);
                if (w_tick) r_qidx <= r_qidx + 2'd1;
                if (w_nack_sample) r_ack_err <= 1'b1;
                if ((r_state == S_BIT) && w_qend) begin
                    r_bit <= r_bit + 6'd1;
                    // ACK slots consume no data, so the shifter only moves on data bits.
                    if (!w_ack_slot) r_shift <= {r_shift[30:0], 1'b0};
                end
            end
        end
    end

    assign scl     = r_scl;
    assign sda_oe  = r_sda_oe;
    assign cfg_end = r_cfg_end;
    assign busy    = r_busy;
    assign ack_err = r_ack_err;

endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master: a bus-level slave/monitor decodes
// bytes from SCL rising edges and acknowledges (or withholds ACK), while a
// table of transactions carries the expected latency, byte count and ack_err.
module tb_sccb_write_master;

    localparam int SYS_HZ = 1600;
    localparam int SCL_HZ = 100;
    localparam int QTR    = SYS_HZ / (4 * SCL_HZ);

`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        cfg_start = 1'b0;
    logic [23:0] cfg_data  = 24'd0;
    logic        cfg_end, busy, ack_err, scl, sda_oe, sda_i;
    logic        slave_low = 1'b0;

    assign sda_i = ~(sda_oe | slave_low);

    sccb_write_master #(
        .DEVICE_ID   (7'h3C),
        .SYS_CLK_FREQ(SYS_HZ),
        .SCL_FREQ    (SCL_HZ)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_start(cfg_start),
        .cfg_data (cfg_data),
        .cfg_end  (cfg_end),
        .busy     (busy),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i)
    );

    always #5 sys_clk = ~sys_clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] data;
        int          nack;      // byte index the slave refuses, 4 = none
        bit          poke_end;  // raise cfg_start during the cfg_end cycle
        bit          poke_mid;  // raise cfg_start mid-transfer
        int          exp_lat;
        int          exp_nbytes;
        bit          exp_err;
    } vec_t;

    // Bus monitor and slave
    int         n_starts  = 0;
    int         n_stops   = 0;
    int         n_glitch  = 0;
    int         pos       = 0;
    int         nack_byte = 4;
    bit         in_frame  = 1'b0;
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    logic [7:0] cur       = 8'd0;
    logic [7:0] got[$];

    always @(negedge sys_clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda_i;
        if (sys_rst) begin
            in_frame  = 1'b0;
            slave_low = 1'b0;
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
        end else begin
            if (prev_scl && s_scl && prev_sda && !s_sda) begin
                in_frame = 1'b1;
                pos      = 0;
                n_starts++;
            end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
                if (in_frame) n_stops++;
                in_frame  = 1'b0;
                slave_low = 1'b0;
            end
            if (!prev_scl && s_scl && in_frame) begin
                if (pos % 9 != 8) begin
                    cur = {cur[6:0], s_sda};
                    if (pos % 9 == 7) got.push_back(cur);
                end
                pos++;
            end
            if (prev_scl && !s_scl) begin
                if (!in_frame) n_glitch++;
                else slave_low = (pos % 9 == 8) && (pos < 36) && (pos / 9 != nack_byte);
            end
            prev_scl = s_scl;
            prev_sda = s_sda;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a NACKed byte n truncates the frame to n+1 bytes when checking
    // is enabled; every byte costs 36 quarters, framed by 4+4 quarters.
    function automatic vec_t mk(input logic [23:0] d, input int nk, input bit pe, input bit pm);
        vec_t v;
        bit   abort;
        abort        = ACK_EN && (nk < 4);
        v.data       = d;
        v.nack       = nk;
        v.poke_end   = pe;
        v.poke_mid   = pm;
        v.exp_err    = abort;
        v.exp_nbytes = abort ? nk + 1 : 4;
        v.exp_lat    = 1 + QTR * (4 + 36 * v.exp_nbytes + 4);
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int          end_c, gap, st0, sp0, late;
        logic [31:0] word;
        got.delete();
        nack_byte = v.nack;
        st0       = n_starts;
        sp0       = n_stops;
        word      = {8'h78, v.data};
        cfg_data  = v.data;
        cfg_start = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_start = 1'b0;
        cfg_data  = 24'($urandom);
        chk("busy_on_accept", {31'd0, busy}, 32'd1);
        end_c = -1;
        gap   = 0;
        for (int c = 1; c <= 700; c++) begin
            @(posedge sys_clk);
            #1;
            if (v.poke_mid && c == 200) begin
                cfg_data  = 24'h123456;
                cfg_start = 1'b1;
            end
            if (v.poke_mid && c == 201) cfg_start = 1'b0;
            if (end_c >= 0) begin
                chk("cfg_end_one_cycle", {31'd0, cfg_end}, 32'd0);
                chk("busy_after_end", {31'd0, busy}, 32'd0);
                break;
            end
            if (!busy) gap++;
            if (cfg_end) begin
                end_c = c;
                if (v.poke_end) cfg_start = 1'b1;
            end
        end
        chk("cfg_end_seen", {31'd0, end_c >= 0}, 32'd1);
        chk("latency", end_c, v.exp_lat);
        chk("busy_window", gap, 0);
        chk("ack_err", {31'd0, ack_err}, {31'd0, v.exp_err});
        chk("byte_count", got.size(), v.exp_nbytes);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("byte%0d", i), got[i], word[31-8*i -: 8]);
        chk("start_count", n_starts - st0, 1);
        chk("stop_count", n_stops - sp0, 1);
        if (v.poke_mid) begin
            late = 0;
            st0  = n_starts;
            repeat (40) begin
                @(posedge sys_clk);
                #1;
                if (busy) late++;
            end
            chk("no_extra_txn_busy", late, 0);
            chk("no_extra_txn_start", n_starts - st0, 0);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int   n_end, n_busy;

        tbl[0] = mk(24'h300882, 4, 1'b1, 1'b0);
        tbl[1] = mk(24'h3017ff, 4, 1'b0, 1'b0);
        tbl[2] = mk(24'h300882, 4, 1'b0, 1'b1);
        tbl[3] = mk(24'h300882, 1, 1'b0, 1'b0);
        tbl[4] = mk(24'h3017ff, 4, 1'b0, 1'b0);
        for (int i = 5; i < 9; i++)
            tbl[i] = mk(24'($urandom), $urandom_range(0, 4), 1'b0, 1'b0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_cfg_end", {31'd0, cfg_end}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        #2 sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("idle_scl", {31'd0, scl}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Reset while bit 20 (addr-low MSB-2, a 0) is on the bus with SCL low.
        nack_byte = 4;
        cfg_data  = 24'h300882;
        cfg_start = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_start = 1'b0;
        repeat (337) @(posedge sys_clk);
        #3;
        chk("pre_rst_scl_low", {31'd0, scl}, 32'd0);
        chk("pre_rst_sda_driven", {31'd0, sda_oe}, 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("abort_scl", {31'd0, scl}, 32'd1);
        chk("abort_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cfg_end", {31'd0, cfg_end}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #4 sys_rst = 1'b0;
        n_end  = 0;
        n_busy = 0;
        repeat (700) begin
            @(posedge sys_clk);
            #1;
            if (cfg_end) n_end++;
            if (busy) n_busy++;
        end
        chk("abort_no_cfg_end", n_end, 0);
        chk("abort_no_busy", n_busy, 0);
        run_txn(mk(24'h300882, 4, 1'b0, 1'b0));

        chk("scl_glitch_outside_frame", n_glitch, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
